config_bitstream_loader: RTL and testbench

//  Serial configuration loader for the FPGA fabric. Hunts a sync word on a 1-bit valid/ready stream.

---
 rtl/config_bitstream_loader.sv | 166 ++++++++++++++++
 tb/tb_config_bitstream_loader.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/config_bitstream_loader.sv
// Serial configuration loader: hunts a sync word on a 1-bit valid/ready stream, deserialises
// addressed frames into parallel config writes and verifies a trailing ones-count checksum.
//
// state   | meaning
// HUNT    | sliding 16-bit window searches for the sync word
// COUNT   | receiving 8-bit frame count
// FRAME   | receiving type + addr + payload; write issued after last bit
// CHECK   | receiving 8-bit expected checksum
// DONE    | load complete, checksum matched; waits for start
// ERROR   | checksum mismatch; waits for start
module config_bitstream_loader #(
  parameter logic [15:0] SYNC_WORD = 16'hA5C3,
  parameter int          ADDR_W    = 7,
  parameter int          DATA_W    = 33
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              cfg_valid,
  input  logic              cfg_data,
  output logic              cfg_ready,
  output logic              wr_en,
  output logic              wr_type,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              done,
  output logic              error
);

  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int BCNT_W  = $clog2(FRAME_W + 1);
  localparam logic [BCNT_W-1:0] FRAME_LAST = BCNT_W'(FRAME_W - 1);
  localparam logic [BCNT_W-1:0] BYTE_LAST  = BCNT_W'(7);

  typedef enum logic [2:0] {
    S_HUNT,
    S_COUNT,
    S_FRAME,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t              state;
  logic [14:0]         window;
  logic [4:0]          hunt_cnt;
  logic [FRAME_W-2:0]  shreg;
  logic [BCNT_W-1:0]   bit_cnt;
  logic [7:0]          frames_left;
  logic [7:0]          cksum;

  logic                xfer;
  logic [15:0]         window_nxt;
  logic [FRAME_W-1:0]  shreg_nxt;

  assign xfer       = cfg_valid & cfg_ready;
  assign window_nxt = {window, cfg_data};
  assign shreg_nxt  = {shreg, cfg_data};

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= S_HUNT;
      window      <= '0;
      hunt_cnt    <= '0;
      shreg       <= '0;
      bit_cnt     <= '0;
      frames_left <= '0;
      cksum       <= '0;
      cfg_ready   <= 1'b0;
      wr_en       <= 1'b0;
      wr_type     <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        S_HUNT: begin
          cfg_ready <= 1'b1;
          if (xfer) begin
            window <= window_nxt[14:0];
            if (hunt_cnt != 5'd16) hunt_cnt <= hunt_cnt + 5'd1;
            // hunt_cnt counts earlier bits, so 15 means this bit completes a full window
            if (window_nxt == SYNC_WORD && hunt_cnt >= 5'd15) begin
              state   <= S_COUNT;
              bit_cnt <= '0;
            end
          end
        end

        S_COUNT: begin
          cfg_ready <= 1'b1;
          if (xfer) begin
            shreg <= shreg_nxt[FRAME_W-2:0];
            if (bit_cnt == BYTE_LAST) begin
              bit_cnt     <= '0;
              frames_left <= shreg_nxt[7:0];
              state       <= (shreg_nxt[7:0] == 8'd0) ? S_CHECK : S_FRAME;
            end else begin
              bit_cnt <= bit_cnt + BCNT_W'(1);
            end
          end
        end

        S_FRAME: begin
          cfg_ready <= 1'b1;
          if (xfer) begin
            shreg <= shreg_nxt[FRAME_W-2:0];
            cksum <= cksum + {7'd0, cfg_data};
            if (bit_cnt == FRAME_LAST) begin
              bit_cnt     <= '0;
              wr_en       <= 1'b1;
              wr_type     <= shreg_nxt[FRAME_W-1];
              wr_addr     <= shreg_nxt[DATA_W +: ADDR_W];
              wr_data     <= shreg_nxt[DATA_W-1:0];
              frames_left <= frames_left - 8'd1;
              if (frames_left == 8'd1) state <= S_CHECK;
            end else begin
              bit_cnt <= bit_cnt + BCNT_W'(1);
            end
          end
        end

        S_CHECK: begin
          cfg_ready <= 1'b1;
          if (xfer) begin
            shreg <= shreg_nxt[FRAME_W-2:0];
            if (bit_cnt == BYTE_LAST) begin
              bit_cnt   <= '0;
              cfg_ready <= 1'b0;
              if (shreg_nxt[7:0] == cksum) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                state <= S_ERROR;
                error <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + BCNT_W'(1);
            end
          end
        end

        S_DONE, S_ERROR: begin
          cfg_ready <= start;
          if (start) begin
            state    <= S_HUNT;
            done     <= 1'b0;
            error    <= 1'b0;
            cksum    <= '0;
            window   <= '0;
            hunt_cnt <= '0;
            bit_cnt  <= '0;
          end
        end

        default: begin
          state     <= S_HUNT;
          cfg_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_config_bitstream_loader.sv
// Self-checking bench for config_bitstream_loader: builds serial streams from frame lists and
// compares observed writes and status against expectations derived from the frame contents.
module tb_config_bitstream_loader;

  localparam logic [15:0] SYNC = 16'hA5C3;
  localparam int FW = 41;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_data = 1'b0;
  logic        cfg_ready, wr_en, wr_type, done, error;
  logic [6:0]  wr_addr;
  logic [32:0] wr_data;

  int total = 0;
  int bad = 0;
  int stall_pct = 0;

  logic          sq[$];
  logic [FW-1:0] fr[$];
  logic [FW-1:0] expq[$];
  logic [FW-1:0] obsq[$];

  always #5 clock = ~clock;

  config_bitstream_loader dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
    .wr_en(wr_en), .wr_type(wr_type), .wr_addr(wr_addr), .wr_data(wr_data),
    .done(done), .error(error)
  );

  always @(negedge clock) if (wr_en) obsq.push_back({wr_type, wr_addr, wr_data});

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_field(input logic [63:0] v, input int w);
    for (int i = w - 1; i >= 0; i--) sq.push_back(v[i]);
  endtask

  function automatic int find_sync();
    logic [15:0] win = '0;
    for (int i = 0; i < sq.size(); i++) begin
      win = {win[14:0], sq[i]};
      if (i >= 15 && win == SYNC) return i;
    end
    return -1;
  endfunction

  // Stream = random prefix (ending with a partial sync when long enough) + sync + count + frames + checksum.
  task automatic build_stream(input int prefix_len, input logic [7:0] ck_delta);
    int sum;
    int first;
    do begin
      sq.delete();
      expq.delete();
      sum = 0;
      for (int i = 0; i < prefix_len - 12; i++) sq.push_back(1'($urandom_range(0, 1)));
      if (prefix_len >= 12) push_field(64'(SYNC >> 4), 12);
      push_field(64'(SYNC), 16);
      push_field(64'(fr.size()), 8);
      foreach (fr[i]) begin
        push_field(64'(fr[i]), FW);
        expq.push_back(fr[i]);
        sum += $countones(fr[i]);
      end
      push_field(64'(8'(sum) + ck_delta), 8);
      first = find_sync();
    end while (first != prefix_len + 15);
  endtask

  task automatic send_bit(input logic b);
    bit sent = 1'b0;
    int tries = 0;
    while (!sent) begin
      @(negedge clock);
      cfg_data  = b;
      cfg_valid = (stall_pct == 0) || ($urandom_range(0, 99) >= stall_pct);
      sent = cfg_valid && cfg_ready;
      tries++;
      if (!sent && tries > 500) begin
        bad++;
        $display("FAIL send_timeout observed=ready_low expected=bit_accepted");
        $fatal(1, "bit not accepted");
      end
    end
  endtask

  task automatic send_range(input int from, input int upto);
    for (int i = from; i < upto; i++) send_bit(sq[i]);
    @(negedge clock);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_end();
    int n = 0;
    while (!(done || error) && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("end_reached", 64'(done | error), 64'd1);
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_wcount"}, 64'(obsq.size()), 64'(expq.size()));
    for (int i = 0; i < obsq.size() && i < expq.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), 64'(obsq[i]), 64'(expq[i]));
  endtask

  task automatic run_load(input string tag, input int prefix_len, input logic [7:0] ck_delta);
    build_stream(prefix_len, ck_delta);
    obsq.delete();
    send_range(0, sq.size());
    wait_end();
    check_writes(tag);
    chk({tag, "_done"}, 64'(done), 64'(ck_delta == 8'd0));
    chk({tag, "_error"}, 64'(error), 64'(ck_delta != 8'd0));
    chk({tag, "_ready"}, 64'(cfg_ready), 64'd0);
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic set_s1_frames();
    fr.delete();
    fr.push_back({1'b0, 7'd3, 33'h1_8000_0001});
    fr.push_back({1'b1, 7'd5, 33'h0_0000_F00F});
  endtask

  initial begin
    int cut;
    reset_n = 1'b0;
    start   = 1'b1;
    repeat (3) @(negedge clock);
    start = 1'b0;
    chk("rst_ready", 64'(cfg_ready), 64'd0);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_wr_fields", 64'({wr_type, wr_addr, wr_data}), 64'd0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("ready_after_reset", 64'(cfg_ready), 64'd1);

    // basic two-frame load
    set_s1_frames();
    run_load("s1", 0, 8'd0);
    chk("s1_hold_type", 64'(wr_type), 64'd1);
    chk("s1_hold_addr", 64'(wr_addr), 64'd5);
    chk("s1_hold_data", 64'(wr_data), 64'h0_0000_F00F);
    pulse_start();
    chk("s1_restart_ready", 64'(cfg_ready), 64'd1);
    chk("s1_restart_done", 64'(done), 64'd0);

    // bad checksum: writes still issued, loader parks in error
    run_load("s2", 0, 8'd1);
    cfg_data  = 1'b1;
    cfg_valid = 1'b1;
    repeat (10) @(negedge clock);
    cfg_valid = 1'b0;
    chk("s2_parked_error", 64'(error), 64'd1);
    chk("s2_parked_ready", 64'(cfg_ready), 64'd0);
    chk("s2_no_extra_writes", 64'(obsq.size()), 64'd2);
    pulse_start();
    chk("s2_restart_ready", 64'(cfg_ready), 64'd1);
    chk("s2_restart_error", 64'(error), 64'd0);

    // garbage prefix with partial sync
    run_load("s3", 37, 8'd0);
    pulse_start();

    // heavy stalls
    stall_pct = 50;
    run_load("s4", 0, 8'd0);
    stall_pct = 0;
    pulse_start();

    // reset at bit 20 of frame 2
    build_stream(0, 8'd0);
    obsq.delete();
    cut = 16 + 8 + FW + 20;
    send_range(0, cut);
    reset_n = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("s5_writes_before_reset", 64'(obsq.size()), 64'd1);
    chk("s5_rst_fields", 64'({wr_en, wr_type, wr_addr, wr_data}), 64'd0);
    chk("s5_rst_status", 64'({cfg_ready, done, error}), 64'd0);
    reset_n = 1'b1;
    run_load("s5_reload", 0, 8'd0);
    pulse_start();

    // empty load
    fr.delete();
    run_load("s6", 0, 8'd0);
    pulse_start();
    chk("s6_restart_ready", 64'(cfg_ready), 64'd1);
    chk("s6_restart_done", 64'(done), 64'd0);

    // randomized frames, stalls and prefix
    for (int r = 0; r < 3; r++) begin
      fr.delete();
      for (int k = 0; k < 2 + r; k++)
        fr.push_back({1'($urandom_range(0, 1)), 7'($urandom), 1'($urandom_range(0, 1)), 32'($urandom)});
      stall_pct = $urandom_range(0, 60);
      run_load($sformatf("rnd%0d", r), 12 + $urandom_range(0, 20), (r == 1) ? 8'd3 : 8'd0);
      pulse_start();
    end
    stall_pct = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
